// File: rtl/lcd8080_bus_engine.sv
// lcd8080_bus_engine: 8080-style parallel LCD bus engine with timed write/read beats
// Ports: clk/rst (async active-high); req_valid/req_ready/req_rs/req_rd/req_data request port;
//        rsp_valid/rsp_data read response; busy = !req_ready;
//        lcd_cs_n/lcd_rs/lcd_wr_n/lcd_rd_n/lcd_d_out/lcd_d_oe/lcd_d_in panel pins.
module lcd8080_bus_engine #(
  parameter int BUS_W      = 16,
  parameter int SETUP_CYC  = 1,
  parameter int WR_LOW_CYC = 1,
  parameter int RD_LOW_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rs,
  input  logic             req_rd,
  input  logic [15:0]      req_data,
  output logic             rsp_valid,
  output logic [15:0]      rsp_data,
  output logic             busy,
  output logic             lcd_cs_n,
  output logic             lcd_rs,
  output logic             lcd_wr_n,
  output logic             lcd_rd_n,
  output logic [BUS_W-1:0] lcd_d_out,
  output logic             lcd_d_oe,
  input  logic [BUS_W-1:0] lcd_d_in
);
  localparam int BEATS = (BUS_W == 8) ? 2 : 1;
  localparam int M_A   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int M_B   = (WR_LOW_CYC > RD_LOW_CYC) ? WR_LOW_CYC : RD_LOW_CYC;
  localparam int MAXP  = (M_A > M_B) ? M_A : M_B;
  localparam int CW    = $clog2(MAXP) + 1;

  if (!(BUS_W == 8 || BUS_W == 16) || SETUP_CYC < 1 || WR_LOW_CYC < 1 ||
      RD_LOW_CYC < 1 || HOLD_CYC < 1) begin : g_bad_params
    $fatal(1, "lcd8080_bus_engine: illegal parameters");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_beat, w_beat_next;
  logic             r_rs, r_rd, r_cs_n, r_wr_n, r_rd_n, r_oe, r_rsp_valid;
  logic [15:0]      r_data, r_rx, r_rsp_data;
  logic [BUS_W-1:0] r_d_out, w_d_first, w_d_second;
  logic [15:0]      w_rx_next;
  logic             w_accept, w_cnt_zero, w_last, w_end_strobe, w_end_xact, w_next_beat, w_rd_eff;
  logic [CW-1:0]    w_low;

  // 8-bit panels send the high byte first and shift read samples in MSB-first
  if (BUS_W == 8) begin : g_b8
    assign w_d_first  = req_data[15:8];
    assign w_d_second = r_data[7:0];
    assign w_rx_next  = {r_rx[7:0], lcd_d_in};
  end else begin : g_b16
    assign w_d_first  = req_data[BUS_W-1:0];
    assign w_d_second = r_data[BUS_W-1:0];
    assign w_rx_next  = lcd_d_in;
  end

  assign req_ready    = (r_state == IDLE) && !rst;
  assign busy         = !req_ready;
  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_last       = (r_beat == 1'(BEATS - 1));
  assign w_low        = r_rd ? CW'(RD_LOW_CYC - 1) : CW'(WR_LOW_CYC - 1);
  assign w_end_strobe = (r_state == STROBE) && w_cnt_zero;
  assign w_end_xact   = (r_state == HOLD) && w_cnt_zero && w_last;
  assign w_next_beat  = (r_state == HOLD) && w_cnt_zero && !w_last;
  assign w_rd_eff     = w_accept ? req_rd : r_rd;

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt - 1'b1;
    w_beat_next = r_beat;
    case (r_state)
      IDLE: begin
        w_cnt_next = r_cnt;
        if (w_accept) begin
          w_next      = SETUP;
          w_cnt_next  = CW'(SETUP_CYC - 1);
          w_beat_next = 1'b0;
        end
      end
      SETUP: if (w_cnt_zero) begin
        w_next     = STROBE;
        w_cnt_next = w_low;
      end
      STROBE: if (w_cnt_zero) begin
        w_next     = HOLD;
        w_cnt_next = CW'(HOLD_CYC - 1);
      end
      default: if (w_cnt_zero) begin
        w_next      = w_last ? IDLE : SETUP;
        w_cnt_next  = CW'(SETUP_CYC - 1);
        w_beat_next = w_last ? r_beat : 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_beat  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_beat  <= w_beat_next;
    end

  // Pins are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cs_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_rs        <= 1'b0;
      r_rd        <= 1'b0;
      r_data      <= '0;
      r_d_out     <= '0;
      r_rx        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_cs_n      <= (w_next == IDLE);
      r_wr_n      <= !((w_next == STROBE) && !r_rd);
      r_rd_n      <= !((w_next == STROBE) && r_rd);
      r_oe        <= (w_next != IDLE) && !w_rd_eff;
      r_rsp_valid <= w_end_xact && r_rd;
      if (w_accept) begin
        r_rs   <= req_rs;
        r_rd   <= req_rd;
        r_data <= req_data;
      end
      if (w_accept && !req_rd) r_d_out <= w_d_first;
      else if (w_next_beat && !r_rd) r_d_out <= w_d_second;
      if (w_end_strobe && r_rd) r_rx <= w_rx_next;
      if (w_end_xact && r_rd) r_rsp_data <= r_rx;
    end

  assign lcd_cs_n  = r_cs_n;
  assign lcd_rs    = r_rs;
  assign lcd_wr_n  = r_wr_n;
  assign lcd_rd_n  = r_rd_n;
  assign lcd_d_out = r_d_out;
  assign lcd_d_oe  = r_oe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_lcd8080_bus_engine.sv
// tb_lcd8080_bus_engine: table-driven bench over three engine configurations
module tb_lcd8080_bus_engine;
  localparam int BW[3] = '{16, 8, 16};
  localparam int SU[3] = '{1, 1, 2};
  localparam int WL[3] = '{1, 1, 3};
  localparam int RL[3] = '{2, 2, 2};
  localparam int HO[3] = '{1, 1, 2};

  typedef struct {
    int          u;
    logic        rs;
    logic        rd;
    logic        b2b;
    logic [15:0] data;
    logic [15:0] bus;
    logic [15:0] exp_rsp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       req_valid = '0, req_rs = '0, req_rd = '0;
  logic [2:0][15:0] req_data = '0, d_in = '0;
  logic [2:0]       req_ready, rsp_valid, busy, cs_n, rs, wr_n, rd_n, oe;
  logic [2:0][15:0] rsp_data, d_out;
  logic [7:0]       d_out_b;
  assign d_out[1] = {8'h00, d_out_b};

  int checks = 0, errors = 0, cyc = 0;
  int last_acc[3] = '{0, 0, 0};
  int last_t[3] = '{0, 0, 0};
  bit b2b_prev[3] = '{0, 0, 0};
  vec_t tv[$];

  always @(posedge clk) cyc <= cyc + 1;

  lcd8080_bus_engine u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rs(req_rs[0]),
    .req_rd(req_rd[0]), .req_data(req_data[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .busy(busy[0]), .lcd_cs_n(cs_n[0]), .lcd_rs(rs[0]), .lcd_wr_n(wr_n[0]), .lcd_rd_n(rd_n[0]),
    .lcd_d_out(d_out[0]), .lcd_d_oe(oe[0]), .lcd_d_in(d_in[0]));

  lcd8080_bus_engine #(.BUS_W(8)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rs(req_rs[1]),
    .req_rd(req_rd[1]), .req_data(req_data[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .busy(busy[1]), .lcd_cs_n(cs_n[1]), .lcd_rs(rs[1]), .lcd_wr_n(wr_n[1]), .lcd_rd_n(rd_n[1]),
    .lcd_d_out(d_out_b), .lcd_d_oe(oe[1]), .lcd_d_in(d_in[1][7:0]));

  lcd8080_bus_engine #(.SETUP_CYC(2), .WR_LOW_CYC(3), .HOLD_CYC(2)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_rs(req_rs[2]),
    .req_rd(req_rd[2]), .req_data(req_data[2]), .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]),
    .busy(busy[2]), .lcd_cs_n(cs_n[2]), .lcd_rs(rs[2]), .lcd_wr_n(wr_n[2]), .lcd_rd_n(rd_n[2]),
    .lcd_d_out(d_out[2]), .lcd_d_oe(oe[2]), .lcd_d_in(d_in[2]));

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic chkb(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b want %b", n, a, e);
    end
  endtask

  // Strobes must never overlap and never be low with chip select released
  always @(negedge clk)
    if (!rst)
      for (int u = 0; u < 3; u++) begin
        checks++;
        if ((!wr_n[u] && !rd_n[u]) || ((!wr_n[u] || !rd_n[u]) && cs_n[u])) begin
          errors++;
          $display("FAIL strobe_overlap u%0d: got cs_n=%b wr_n=%b rd_n=%b want no overlap", u, cs_n[u], wr_n[u], rd_n[u]);
        end
      end

  task automatic xact(input vec_t v);
    int u, bl, t, k, o, acc;
    logic st;
    logic [15:0] ed;
    string p;
    u  = v.u;
    bl = SU[u] + (v.rd ? RL[u] : WL[u]) + HO[u];
    t  = (BW[u] == 8 ? 2 : 1) * bl;
    ed = '0;
    req_valid[u] = 1'b1;
    req_rs[u]    = v.rs;
    req_rd[u]    = v.rd;
    req_data[u]  = v.data;
    chkb($sformatf("u%0d ready_before_accept", u), req_ready[u], 1'b1);
    @(posedge clk);
    acc = cyc;
    if (b2b_prev[u]) chk($sformatf("u%0d accept_gap", u), 16'(acc - last_acc[u]), 16'(last_t[u] + 1));
    last_acc[u] = acc;
    last_t[u]   = t;
    b2b_prev[u] = v.b2b;
    @(negedge clk);
    req_valid[u] = v.b2b;
    req_data[u]  = ~v.data;
    req_rs[u]    = ~v.rs;
    req_rd[u]    = ~v.rd;
    for (int c = 0; c < t; c++) begin
      k  = c / bl;
      o  = c % bl;
      st = (o >= SU[u]) && (o < SU[u] + (v.rd ? RL[u] : WL[u]));
      ed = (BW[u] == 8) ? ((k == 0) ? {8'h00, v.data[15:8]} : {8'h00, v.data[7:0]}) : v.data;
      d_in[u] = (BW[u] == 8) ? ((k == 0) ? {8'h00, v.bus[15:8]} : {8'h00, v.bus[7:0]}) : v.bus;
      p = $sformatf("u%0d c%0d", u, c);
      chkb({p, " cs_n"}, cs_n[u], 1'b0);
      chkb({p, " wr_n"}, wr_n[u], !(st && !v.rd));
      chkb({p, " rd_n"}, rd_n[u], !(st && v.rd));
      chkb({p, " oe"}, oe[u], !v.rd);
      chkb({p, " rs"}, rs[u], v.rs);
      chkb({p, " ready"}, req_ready[u], 1'b0);
      chkb({p, " busy"}, busy[u], 1'b1);
      chkb({p, " rsp_valid"}, rsp_valid[u], 1'b0);
      if (!v.rd) chk({p, " d_out"}, d_out[u], ed);
      @(negedge clk);
    end
    p = $sformatf("u%0d idle", u);
    chkb({p, " cs_n"}, cs_n[u], 1'b1);
    chkb({p, " wr_n"}, wr_n[u], 1'b1);
    chkb({p, " rd_n"}, rd_n[u], 1'b1);
    chkb({p, " oe"}, oe[u], 1'b0);
    chkb({p, " ready"}, req_ready[u], 1'b1);
    chkb({p, " rs_hold"}, rs[u], v.rs);
    chkb({p, " rsp_valid"}, rsp_valid[u], v.rd);
    if (v.rd) chk({p, " rsp_data"}, rsp_data[u], v.exp_rsp);
    else chk({p, " d_out_hold"}, d_out[u], ed);
  endtask

  initial begin
    vec_t r;
    tv.push_back('{0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000});
    tv.push_back('{1, 1'b0, 1'b0, 1'b0, 16'hABCD, 16'h0000, 16'h0000});
    tv.push_back('{1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h5AC3, 16'h5AC3});
    tv.push_back('{2, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h0000, 16'h0000});
    tv.push_back('{2, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h0000, 16'h0000});
    tv.push_back('{0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF});
    tv.push_back('{1, 1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h0000});
    tv.push_back('{0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000});
    tv.push_back('{2, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h8001, 16'h8001});
    tv.push_back('{1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0102, 16'h0102});
    tv.push_back('{1, 1'b1, 1'b0, 1'b0, 16'h7E81, 16'h0000, 16'h0000});
    for (int i = 0; i < 12; i++) begin
      r.u       = int'($urandom_range(0, 2));
      r.rs      = 1'($urandom_range(0, 1));
      r.rd      = 1'($urandom_range(0, 1));
      r.b2b     = 1'b0;
      r.data    = 16'($urandom);
      r.bus     = 16'($urandom);
      r.exp_rsp = r.bus;
      tv.push_back(r);
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chkb($sformatf("u%0d rst ready", u), req_ready[u], 1'b0);
      chkb($sformatf("u%0d rst busy", u), busy[u], 1'b1);
      chkb($sformatf("u%0d rst cs_n", u), cs_n[u], 1'b1);
      chkb($sformatf("u%0d rst wr_n", u), wr_n[u], 1'b1);
      chkb($sformatf("u%0d rst rd_n", u), rd_n[u], 1'b1);
      chkb($sformatf("u%0d rst rs", u), rs[u], 1'b0);
      chkb($sformatf("u%0d rst oe", u), oe[u], 1'b0);
      chkb($sformatf("u%0d rst rsp_valid", u), rsp_valid[u], 1'b0);
      chk($sformatf("u%0d rst d_out", u), d_out[u], 16'h0000);
      chk($sformatf("u%0d rst rsp_data", u), rsp_data[u], 16'h0000);
    end
    rst = 1'b0;
    @(negedge clk);
    foreach (tv[i]) xact(tv[i]);
    req_valid[0] = 1'b1;
    req_rd[0]    = 1'b1;
    req_rs[0]    = 1'b1;
    chkb("rst_mid ready", req_ready[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chkb("rst_mid in_strobe rd_n", rd_n[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    chkb("rst_mid cs_n", cs_n[0], 1'b1);
    chkb("rst_mid rd_n", rd_n[0], 1'b1);
    chkb("rst_mid wr_n", wr_n[0], 1'b1);
    chkb("rst_mid oe", oe[0], 1'b0);
    chkb("rst_mid ready", req_ready[0], 1'b0);
    chk("rst_mid rsp_data", rsp_data[0], 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1 chkb("rst_mid ready_after", req_ready[0], 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chkb($sformatf("rst_mid rsp_valid c%0d", i), rsp_valid[0], 1'b0);
      chkb($sformatf("rst_mid cs_n c%0d", i), cs_n[0], 1'b1);
    end
    b2b_prev = '{0, 0, 0};
    r = '{0, 1'b1, 1'b0, 1'b0, 16'hC0DE, 16'h0000, 16'h0000};
    xact(r);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
